// File: rtl/axi_master_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_master_bridge_if
//   AXI4 AW/W/B/AR/R channel bundle used between axi_master_bridge and the
//   system bus. Widths come from the AXI_*_BITS macros; defaults are supplied
//   here when the build does not define them.
//
//   modport master : drives AW/W/AR payload + valids, BREADY, RREADY
//   modport slave  : mirror image, for bus models and slaves
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface axi_master_bridge_if;
    // write address
    logic [`AXI_ID_BITS-1:0]   AWID;
    logic [`AXI_ADDR_BITS-1:0] AWADDR;
    logic [`AXI_LEN_BITS-1:0]  AWLEN;
    logic [`AXI_SIZE_BITS-1:0] AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;
    // write data
    logic [`AXI_DATA_BITS-1:0] WDATA;
    logic [`AXI_STRB_BITS-1:0] WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    // write response
    logic [`AXI_ID_BITS-1:0]   BID;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    // read address
    logic [`AXI_ID_BITS-1:0]   ARID;
    logic [`AXI_ADDR_BITS-1:0] ARADDR;
    logic [`AXI_LEN_BITS-1:0]  ARLEN;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    // read data
    logic [`AXI_ID_BITS-1:0]   RID;
    logic [`AXI_DATA_BITS-1:0] RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
//   Converts a simple core request port into AXI4 transactions: INCR read
//   bursts of 1-16 beats and single-beat writes. One transaction in flight.
//   Address/len/data are captured at grant and held unchanged until the
//   transaction completes, so the slave may rely on them during its data
//   phase. WSTRB is forwarded with its polarity untouched.
//
//   Parameters : MASTER_ID    value driven on ARID/AWID
//   Optional   : `define AXI_MST_RESP_CHK_EN enables sticky response /
//                burst-length error reporting on core_err (otherwise 0).
//
//   Ports
//     ACLK, ARESETn          clock, async active-low reset
//     core_req/we/addr/len   request (sampled in IDLE only)
//     core_wdata/wstrb       write payload
//     core_gnt               request accepted this cycle (combinational)
//     core_busy              transaction in progress
//     core_rvalid/rdata/rlast registered read beat, one cycle per beat
//     core_done              registered completion pulse
//     core_err               sticky error flag
//     axi                    AXI4 master channels
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_master_bridge #(
    parameter int unsigned MASTER_ID = 0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [3:0]  core_len,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wstrb,
    output logic        core_gnt,
    output logic        core_busy,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_rlast,
    output logic        core_done,
    output logic        core_err,
    axi_master_bridge_if.master axi
);

    localparam int unsigned IDW   = `AXI_ID_BITS;
    localparam int unsigned LENW  = `AXI_LEN_BITS;
    localparam int unsigned SIZEW = `AXI_SIZE_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q;
    logic [4:0]  beat_cnt;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        r_close;

    // ---------------------------------------------------------------------
    // Handshakes. Valid/ready outputs decode from state only, so each
    // handshake is just "in that state and the other side agrees".
    // ---------------------------------------------------------------------
    assign ar_hs = (state_q == ST_AR) && axi.ARREADY;
    assign r_hs  = (state_q == ST_R)  && axi.RVALID;
    assign aw_hs = (state_q == ST_AW) && axi.AWREADY;
    assign w_hs  = (state_q == ST_W)  && axi.WREADY;
    assign b_hs  = (state_q == ST_B)  && axi.BVALID;

    // Grant is withheld in the core_done cycle so the next grant lands at
    // the earliest one cycle after completion; gated by reset so no pulse
    // escapes while the block is held in reset.
    assign core_gnt  = ARESETn && (state_q == ST_IDLE) && core_req && !core_done;
    assign core_busy = (state_q != ST_IDLE);

`ifdef AXI_MST_RESP_CHK_EN
    // Beat being received now is number beat_cnt+1; it should be the last
    // exactly when beat_cnt equals the latched len.
    logic beat_final;
    assign beat_final = (beat_cnt == {1'b0, req_q.len});
    // A burst that reaches its length without RLAST is closed anyway.
    assign r_close    = r_hs && (axi.RLAST || beat_final);
`else
    assign r_close    = r_hs && axi.RLAST;
`endif

    // ---------------------------------------------------------------------
    // State machine
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (core_gnt)    state_d = core_we ? ST_AW : ST_AR;
            ST_AR:   if (ar_hs)       state_d = ST_R;
            ST_R:    if (r_close)     state_d = ST_IDLE;
            ST_AW:   if (aw_hs)       state_d = ST_W;
            ST_W:    if (w_hs)        state_d = ST_B;
            ST_B:    if (b_hs)        state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            beat_cnt    <= '0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            core_rlast  <= 1'b0;
            core_done   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (core_gnt) begin
                req_q.addr  <= {core_addr[31:2], 2'b00};
                req_q.len   <= core_len;
                req_q.we    <= core_we;
                req_q.wdata <= core_wdata;
                req_q.wstrb <= core_wstrb;
            end
            if (ar_hs)
                beat_cnt <= '0;
            else if (r_hs)
                beat_cnt <= beat_cnt + 5'd1;
            core_rvalid <= r_hs;
            if (r_hs)
                core_rdata <= axi.RDATA;
            core_rlast  <= r_hs && axi.RLAST;
            core_done   <= r_close || b_hs;
        end
    end

    // ---------------------------------------------------------------------
    // Response / burst-length checking
    // ---------------------------------------------------------------------
`ifdef AXI_MST_RESP_CHK_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            core_err <= 1'b0;
        else if ((r_hs && (axi.RRESP != 2'b00)) ||
                 (b_hs && (axi.BRESP != 2'b00)) ||
                 (r_hs && (axi.RLAST != beat_final)))
            core_err <= 1'b1;
    end
`else
    assign core_err = 1'b0;

    logic unused_rsp;
    assign unused_rsp = &{1'b0, axi.RRESP, axi.BRESP, beat_cnt};
`endif

    // ---------------------------------------------------------------------
    // AXI outputs: all from registered state / latched request
    // ---------------------------------------------------------------------
    assign axi.ARID    = IDW'(MASTER_ID);
    assign axi.ARADDR  = req_q.addr;
    assign axi.ARLEN   = LENW'(req_q.len);
    assign axi.ARSIZE  = SIZEW'(3'b010);
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = (state_q == ST_AR);
    assign axi.RREADY  = (state_q == ST_R);

    assign axi.AWID    = IDW'(MASTER_ID);
    assign axi.AWADDR  = req_q.addr;
    assign axi.AWLEN   = '0;
    assign axi.AWSIZE  = SIZEW'(3'b010);
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = (state_q == ST_AW);

    assign axi.WDATA   = req_q.wdata;
    assign axi.WSTRB   = req_q.wstrb;
    assign axi.WLAST   = (state_q == ST_W);
    assign axi.WVALID  = (state_q == ST_W);
    assign axi.BREADY  = (state_q == ST_B);

    // Direction is carried by the state; IDs from the slave are not checked.
    logic unused_in;
    assign unused_in = &{1'b0, core_addr[1:0], req_q.we, axi.RID, axi.BID};

endmodule

// File: tb/tb_axi_master_bridge.sv
`timescale 1ns/1ps
module tb_axi_master_bridge;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_len, core_wstrb;
    logic        core_gnt, core_busy, core_rvalid, core_rlast, core_done, core_err;
    logic [31:0] core_rdata;

    axi_master_bridge_if axi();

    axi_master_bridge #(.MASTER_ID(0)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_len    (core_len),
        .core_wdata  (core_wdata),
        .core_wstrb  (core_wstrb),
        .core_gnt    (core_gnt),
        .core_busy   (core_busy),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_rlast  (core_rlast),
        .core_done   (core_done),
        .core_err    (core_err),
        .axi         (axi)
    );

    always #5 ACLK = ~ACLK;

`ifdef AXI_MST_RESP_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
        logic [3:0]  strb;
        int          wait_cyc;
        int          stall_at;
        logic [1:0]  resp;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard: every core_rvalid beat must match the oldest expected beat.
    always @(negedge ACLK) begin
        if (core_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected act=%0h exp=none", core_rdata);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("rdata", core_rdata, e.data);
                chk("rlast", core_rlast, e.last);
            end
        end
    end

    // Read: acts as the slave. Sends nbeats beats, RLAST on the final one if
    // give_last; stall_at inserts a 2-cycle RVALID gap before that beat.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] data,
                           input int wait_cyc, input int stall_at, input logic [1:0] resp,
                           input int nbeats, input logic give_last,
                           input logic [31:0] exp_addr, input logic exp_done);
        core_req = 1'b1; core_we = 1'b0; core_addr = addr; core_len = len;
        #1;
        chk("rd_gnt", core_gnt, 1'b1);
        tick();
        core_req = 1'b0;
        chk("arvalid", axi.ARVALID, 1'b1);
        chk("araddr", axi.ARADDR, exp_addr);
        chk("arlen", axi.ARLEN, {4'b0, len});
        chk("arsize", axi.ARSIZE, 3'b010);
        chk("arburst", axi.ARBURST, 2'b01);
        chk("arid", axi.ARID, 0);
        chk("rd_busy", core_busy, 1'b1);
        repeat (wait_cyc) begin
            tick();
            chk("arvalid_hold", axi.ARVALID, 1'b1);
        end
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        chk("rready", axi.RREADY, 1'b1);
        chk("arvalid_off", axi.ARVALID, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            if (i == stall_at) begin
                axi.RVALID = 1'b0;
                repeat (2) begin
                    tick();
                    chk("rready_stall", axi.RREADY, 1'b1);
                    chk("araddr_stall", axi.ARADDR, exp_addr);
                end
            end
            axi.RVALID = 1'b1;
            axi.RDATA  = data + 32'(i);
            axi.RLAST  = give_last && (i == nbeats - 1);
            axi.RRESP  = resp;
            exp_q.push_back('{data + 32'(i), give_last && (i == nbeats - 1)});
            tick();
            chk("araddr_hold", axi.ARADDR, exp_addr);
        end
        axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
        chk("rd_done", core_done, exp_done);
        chk("rd_busy_end", core_busy, !exp_done);
        tick();
        chk("rd_done_pulse", core_done, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int wait_cyc, input logic [1:0] resp, input logic [31:0] exp_addr);
        core_req = 1'b1; core_we = 1'b1; core_addr = addr; core_len = 4'hF;
        core_wdata = data; core_wstrb = strb;
        #1;
        chk("wr_gnt", core_gnt, 1'b1);
        tick();
        core_req = 1'b0;
        chk("awvalid", axi.AWVALID, 1'b1);
        chk("awaddr", axi.AWADDR, exp_addr);
        chk("awlen", axi.AWLEN, 8'd0);
        chk("awsize", axi.AWSIZE, 3'b010);
        chk("awburst", axi.AWBURST, 2'b01);
        chk("awid", axi.AWID, 0);
        chk("wvalid_early", axi.WVALID, 1'b0);
        repeat (wait_cyc) begin
            tick();
            chk("awvalid_hold", axi.AWVALID, 1'b1);
            chk("awaddr_hold_aw", axi.AWADDR, exp_addr);
        end
        axi.AWREADY = 1'b1;
        tick();
        axi.AWREADY = 1'b0;
        chk("awvalid_off", axi.AWVALID, 1'b0);
        chk("wvalid", axi.WVALID, 1'b1);
        chk("wlast", axi.WLAST, 1'b1);
        chk("wdata", axi.WDATA, data);
        chk("wstrb", axi.WSTRB, strb);
        chk("awaddr_hold_w", axi.AWADDR, exp_addr);
        axi.WREADY = 1'b1;
        tick();
        axi.WREADY = 1'b0;
        chk("wvalid_off", axi.WVALID, 1'b0);
        chk("bready", axi.BREADY, 1'b1);
        chk("awaddr_hold_b", axi.AWADDR, exp_addr);
        axi.BVALID = 1'b1; axi.BRESP = resp;
        tick();
        axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        chk("wr_done", core_done, 1'b1);
        chk("bready_off", axi.BREADY, 1'b0);
        chk("wr_busy_end", core_busy, 1'b0);
        tick();
        chk("wr_done_pulse", core_done, 1'b0);
    endtask

    initial begin
        //          we    addr          len   data          strb    wt st  resp   exp_addr      err
        vecs[0] = '{1'b0, 32'h0000_0010, 4'd0,  32'hDEAD_BEEF, 4'h0,   0, -1, 2'b00, 32'h0000_0010, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0100, 4'd3,  32'hA000_0000, 4'h0,   1,  2, 2'b00, 32'h0000_0100, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0020, 4'd0,  32'h1234_5678, 4'b0000, 3, -1, 2'b00, 32'h0000_0020, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0203, 4'd15, 32'h0000_5500, 4'h0,   0,  0, 2'b00, 32'h0000_0200, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFE, 4'd0,  32'hCAFE_F00D, 4'b1010, 0, -1, 2'b00, 32'hFFFF_FFFC, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0040, 4'd0,  32'h0000_0001, 4'b1111, 1, -1, 2'b10, 32'h0000_0040, CHK};
        vecs[6] = '{1'b0, 32'h0000_0080, 4'd2,  32'h0000_0077, 4'h0,   0,  1, 2'b00, 32'h0000_0080, CHK};
        vecs[7] = '{1'b0, 32'h0000_0090, 4'd0,  32'h0000_0099, 4'h0,   2, -1, 2'b00, 32'h0000_0090, CHK};

        ARESETn = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_len = '0;
        core_wdata = '0; core_wstrb = '0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BVALID = 1'b0; axi.BRESP = 2'b00; axi.BID = '0;
        axi.ARREADY = 1'b0;
        axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00; axi.RLAST = 1'b0; axi.RID = '0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        tick();

        // reset state
        chk("rst_arvalid", axi.ARVALID, 1'b0);
        chk("rst_awvalid", axi.AWVALID, 1'b0);
        chk("rst_wvalid", axi.WVALID, 1'b0);
        chk("rst_rready", axi.RREADY, 1'b0);
        chk("rst_bready", axi.BREADY, 1'b0);
        chk("rst_busy", core_busy, 1'b0);
        chk("rst_done", core_done, 1'b0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_araddr", axi.ARADDR, 32'h0);
        chk("rst_err", core_err, 1'b0);

        // unexpected RVALID / BVALID in IDLE are not acknowledged
        axi.RVALID = 1'b1; axi.RLAST = 1'b1; axi.RDATA = 32'hBAD0_BAD0;
        axi.BVALID = 1'b1; axi.BRESP = 2'b10;
        #1;
        chk("idle_rready", axi.RREADY, 1'b0);
        chk("idle_bready", axi.BREADY, 1'b0);
        tick();
        axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        chk("idle_rvalid", core_rvalid, 1'b0);
        chk("idle_done", core_done, 1'b0);
        chk("idle_err", core_err, 1'b0);

        // table-driven transactions
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].we)
                do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].wait_cyc,
                         vecs[k].resp, vecs[k].exp_addr);
            else
                do_read(vecs[k].addr, vecs[k].len, vecs[k].data, vecs[k].wait_cyc,
                        vecs[k].stall_at, vecs[k].resp, int'(vecs[k].len) + 1, 1'b1,
                        vecs[k].exp_addr, 1'b1);
            chk($sformatf("vec%0d_err", k), core_err, vecs[k].exp_err);
            tick();
        end

        // core_req held high: one grant per IDLE visit, none in the done cycle
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h300; core_len = 4'd0;
        #1;
        chk("b2b_gnt0", core_gnt, 1'b1);
        tick();
        chk("b2b_gnt_ar", core_gnt, 1'b0);
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        chk("b2b_gnt_r", core_gnt, 1'b0);
        axi.RVALID = 1'b1; axi.RDATA = 32'h3333; axi.RLAST = 1'b1;
        exp_q.push_back('{32'h3333, 1'b1});
        tick();
        axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        chk("b2b_done", core_done, 1'b1);
        chk("b2b_gnt_done", core_gnt, 1'b0);
        tick();
        chk("b2b_gnt1", core_gnt, 1'b1);
        tick();
        core_req = 1'b0;
        chk("b2b_arvalid2", axi.ARVALID, 1'b1);
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        axi.RVALID = 1'b1; axi.RDATA = 32'h4444; axi.RLAST = 1'b1;
        exp_q.push_back('{32'h4444, 1'b1});
        tick();
        axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        chk("b2b_done2", core_done, 1'b1);
        tick();

        // reset mid-burst: everything drops at once, no core_done
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h600; core_len = 4'd3;
        tick();
        core_req = 1'b0;
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.RVALID = 1'b1; axi.RDATA = 32'h6000 + 32'(i); axi.RLAST = 1'b0;
            exp_q.push_back('{32'h6000 + 32'(i), 1'b0});
            tick();
        end
        axi.RVALID = 1'b0;
        tick();
        ARESETn = 1'b0;
        core_req = 1'b1;
        #1;
        chk("mrst_rready", axi.RREADY, 1'b0);
        chk("mrst_arvalid", axi.ARVALID, 1'b0);
        chk("mrst_awvalid", axi.AWVALID, 1'b0);
        chk("mrst_wvalid", axi.WVALID, 1'b0);
        chk("mrst_bready", axi.BREADY, 1'b0);
        chk("mrst_busy", core_busy, 1'b0);
        chk("mrst_rvalid", core_rvalid, 1'b0);
        chk("mrst_gnt", core_gnt, 1'b0);
        chk("mrst_done", core_done, 1'b0);
        chk("mrst_err", core_err, 1'b0);
        chk("mrst_rdata", core_rdata, 32'h0);
        repeat (2) begin
            tick();
            chk("mrst_done_hold", core_done, 1'b0);
        end
        core_req = 1'b0;
        ARESETn = 1'b1;
        tick();
        chk("mrst_idle", core_busy, 1'b0);
        chk("mrst_done_after", core_done, 1'b0);

        // RRESP error
        do_read(32'h700, 4'd0, 32'h7777, 0, -1, 2'b10, 1, 1'b1, 32'h700, 1'b1);
        chk("rresp_err", core_err, CHK);
        tick();
        chk("rresp_err_sticky", core_err, CHK);
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        chk("err_cleared", core_err, 1'b0);

        // RLAST on beat 2 of a 4-beat burst
        do_read(32'h500, 4'd3, 32'h5000, 0, -1, 2'b00, 2, 1'b1, 32'h500, 1'b1);
        chk("early_last_err", core_err, CHK);
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();

        // beat len+1 without RLAST: closed only when checking is enabled
        do_read(32'h800, 4'd1, 32'h8000, 0, -1, 2'b00, 2, 1'b0, 32'h800, CHK);
        chk("nolast_err", core_err, CHK);
        if (!CHK) begin
            axi.RVALID = 1'b1; axi.RDATA = 32'h8002; axi.RLAST = 1'b1;
            exp_q.push_back('{32'h8002, 1'b1});
            tick();
            axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        end
        tick();
        chk("nolast_idle", core_busy, 1'b0);
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rbeats_missing act=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
